mc_stage_ctrl: RTL and testbench

//  Multi-cycle stage sequencer for the next-generation MIPS32 core; replaces the free-running stage counter.

---
 rtl/mc_stage_ctrl_pkg.sv | 37 +++
 rtl/mc_stage_ctrl_hs_timer.sv | 35 +++
 rtl/mc_stage_ctrl.sv | 159 +++++++++++++++
 tb/tb_mc_stage_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_stage_ctrl_pkg.sv
// Shared types and helpers for the multi-cycle stage sequencer.
//   mc_state_t  : sequencer state encoding
//   stage_en_t  : bundle of one-cycle stage enables driven to the datapath
//   state_busy  : true for the states that belong to an in-flight instruction
//   timer_width : counter width needed to reach a handshake wait limit
package mc_stage_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERROR  = 3'd7
    } mc_state_t;

    typedef struct packed {
        logic if_en;
        logic id_en;
        logic ex_en;
        logic mem_en;
        logic wb_en;
        logic pc_en;
    } stage_en_t;

    function automatic logic state_busy(input mc_state_t s);
        return (s != ST_IDLE) && (s != ST_HALT) && (s != ST_ERROR);
    endfunction

    // A limit of 0 or 1 still needs one flop so the counter port is never zero-width.
    function automatic int unsigned timer_width(input int unsigned limit);
        return (limit < 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/mc_stage_ctrl_hs_timer.sv
// Handshake wait timer shared by FETCH and MEM (never active at the same time).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : zero the count (highest priority after reset)
//   count      : a wait cycle is in progress; advance the count
//   expire_c   : combinational, high on the LIMIT-th consecutive wait cycle
// LIMIT = 0 disables expiry entirely.
module mc_stage_ctrl_hs_timer
    import mc_stage_ctrl_pkg::*;
#(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expire_c
);

    localparam int unsigned TMR_W = timer_width(LIMIT);

    logic [TMR_W-1:0] cnt;

    // Wait-cycle counter; wraps harmlessly when LIMIT is 0.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (count) begin
            cnt <= cnt + TMR_W'(1);
        end
    end

    assign expire_c = (LIMIT != 0) && count && (cnt == TMR_W'(LIMIT - 1));

endmodule

// File: rtl/mc_stage_ctrl.sv
// Multi-cycle stage sequencer: steps one instruction at a time through
// FETCH/DECODE/EXEC/[MEM]/WB on a single clock, emitting one-cycle enables.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   run, halt_req            : start/continue, stop after current retire (both sampled in WB)
//   inst_ready, mem_ready    : memory handshake completions (ignored when not requesting)
//   mem_access, reg_write    : decoded instruction attributes
//   inst_req, mem_req        : handshake requests, held until ready
//   if_en..wb_en, pc_en      : stage enable pulses
//   busy, halted, timeout_err: status
//   cycle_count, retired_count: wrapping busy-cycle and retire counters
// Handshake completions are Mealy: the enable rises in the same cycle ready arrives.
module mc_stage_ctrl
    import mc_stage_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned TIMEOUT  = 16,
    parameter bit          SKIP_MEM = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             halt_req,
    input  logic             inst_ready,
    input  logic             mem_access,
    input  logic             reg_write,
    input  logic             mem_ready,
    output logic             inst_req,
    output logic             mem_req,
    output logic             if_en,
    output logic             id_en,
    output logic             ex_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic             busy,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
);

    mc_state_t        state;
    mc_state_t        state_nxt;
    stage_en_t        en_c;
    logic             inst_req_c;
    logic             mem_req_c;
    logic             wait_c;
    logic             expire_c;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] retired_q;

    // Counting only while a handshake is outstanding; any other cycle clears,
    // so the count always starts at zero on entry to FETCH or MEM.
    mc_stage_ctrl_hs_timer #(
        .LIMIT (TIMEOUT)
    ) u_hs_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (!wait_c),
        .count    (wait_c),
        .expire_c (expire_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and stage enables.
    always_comb begin
        state_nxt  = state;
        en_c       = '0;
        inst_req_c = 1'b0;
        mem_req_c  = 1'b0;
        wait_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                inst_req_c = 1'b1;
                if (inst_ready) begin
                    en_c.if_en = 1'b1;
                    state_nxt  = ST_DECODE;
                end else begin
                    wait_c = 1'b1;
                    if (expire_c) state_nxt = ST_ERROR;
                end
            end
            ST_DECODE: begin
                en_c.id_en = 1'b1;
                state_nxt  = ST_EXEC;
            end
            ST_EXEC: begin
                en_c.ex_en = 1'b1;
                state_nxt  = (mem_access || !SKIP_MEM) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                mem_req_c = mem_access;
                if (!mem_access) begin
                    // Dummy MEM visit when skipping is disabled.
                    state_nxt = ST_WB;
                end else if (mem_ready) begin
                    en_c.mem_en = 1'b1;
                    state_nxt   = ST_WB;
                end else begin
                    wait_c = 1'b1;
                    if (expire_c) state_nxt = ST_ERROR;
                end
            end
            ST_WB: begin
                en_c.pc_en = 1'b1;
                en_c.wb_en = reg_write;
                if (halt_req) begin
                    state_nxt = ST_HALT;
                end else if (!run) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_HALT:  state_nxt = ST_HALT;
            ST_ERROR: state_nxt = ST_ERROR;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Busy-cycle and retire counters, both wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            if (state_busy(state)) cycle_q <= cycle_q + CNT_W'(1);
            if (en_c.pc_en) retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Reset masks the Mealy outputs so an aborted instruction emits nothing.
    assign inst_req      = inst_req_c && !rst;
    assign mem_req       = mem_req_c && !rst;
    assign if_en         = en_c.if_en && !rst;
    assign id_en         = en_c.id_en && !rst;
    assign ex_en         = en_c.ex_en && !rst;
    assign mem_en        = en_c.mem_en && !rst;
    assign wb_en         = en_c.wb_en && !rst;
    assign pc_en         = en_c.pc_en && !rst;
    assign busy          = state_busy(state) && !rst;
    assign halted        = (state == ST_HALT) && !rst;
    assign timeout_err   = (state == ST_ERROR) && !rst;
    assign cycle_count   = cycle_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_mc_stage_ctrl.sv
// Bench for mc_stage_ctrl. Two instances: A (SKIP_MEM=1, TIMEOUT=4, 8-bit
// counters) and B (SKIP_MEM=0, no timeout, 32-bit counters). Each instruction
// is described as a plan (wait lengths, attributes, WB decisions); the plan is
// expanded into the expected per-cycle output waveform while inputs are driven.
module tb_mc_stage_ctrl;

    localparam int unsigned TO_A = 4;
    localparam int unsigned CW_A = 8;
    localparam int unsigned CW_B = 32;

    typedef struct packed {
        logic inst_req;
        logic mem_req;
        logic if_en;
        logic id_en;
        logic ex_en;
        logic mem_en;
        logic wb_en;
        logic pc_en;
        logic busy;
        logic halted;
        logic timeout_err;
    } flags_t;

    typedef struct {
        int fdly;
        bit macc;
        int mdly;
        bit rw;
        bit wb_run;
        bit wb_halt;
        bit abort_mem;
    } instr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst [2];
    logic run [2];
    logic halt_req [2];
    logic inst_ready [2];
    logic mem_access [2];
    logic reg_write [2];
    logic mem_ready [2];

    logic a_inst_req, a_mem_req, a_if_en, a_id_en, a_ex_en, a_mem_en, a_wb_en, a_pc_en;
    logic a_busy, a_halted, a_timeout_err;
    logic b_inst_req, b_mem_req, b_if_en, b_id_en, b_ex_en, b_mem_en, b_wb_en, b_pc_en;
    logic b_busy, b_halted, b_timeout_err;
    logic [CW_A-1:0] cyc_a, ret_a;
    logic [CW_B-1:0] cyc_b, ret_b;

    flags_t act_a, act_b;
    assign act_a = {a_inst_req, a_mem_req, a_if_en, a_id_en, a_ex_en, a_mem_en,
                    a_wb_en, a_pc_en, a_busy, a_halted, a_timeout_err};
    assign act_b = {b_inst_req, b_mem_req, b_if_en, b_id_en, b_ex_en, b_mem_en,
                    b_wb_en, b_pc_en, b_busy, b_halted, b_timeout_err};

    mc_stage_ctrl #(.CNT_W(CW_A), .TIMEOUT(TO_A), .SKIP_MEM(1'b1)) dut_a (
        .clk(clk), .rst(rst[0]), .run(run[0]), .halt_req(halt_req[0]),
        .inst_ready(inst_ready[0]), .mem_access(mem_access[0]), .reg_write(reg_write[0]),
        .mem_ready(mem_ready[0]), .inst_req(a_inst_req), .mem_req(a_mem_req),
        .if_en(a_if_en), .id_en(a_id_en), .ex_en(a_ex_en), .mem_en(a_mem_en),
        .wb_en(a_wb_en), .pc_en(a_pc_en), .busy(a_busy), .halted(a_halted),
        .timeout_err(a_timeout_err), .cycle_count(cyc_a), .retired_count(ret_a)
    );

    mc_stage_ctrl #(.CNT_W(CW_B), .TIMEOUT(0), .SKIP_MEM(1'b0)) dut_b (
        .clk(clk), .rst(rst[1]), .run(run[1]), .halt_req(halt_req[1]),
        .inst_ready(inst_ready[1]), .mem_access(mem_access[1]), .reg_write(reg_write[1]),
        .mem_ready(mem_ready[1]), .inst_req(b_inst_req), .mem_req(b_mem_req),
        .if_en(b_if_en), .id_en(b_id_en), .ex_en(b_ex_en), .mem_en(b_mem_en),
        .wb_en(b_wb_en), .pc_en(b_pc_en), .busy(b_busy), .halted(b_halted),
        .timeout_err(b_timeout_err), .cycle_count(cyc_b), .retired_count(ret_b)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    bit          chk_en = 1'b0;
    flags_t      exp_f [2];
    int unsigned exp_cyc [2];
    int unsigned exp_ret [2];
    bit          pending_fetch [2];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    endtask

    // Single compare process: every cycle, both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("flags_a", 32'(act_a), 32'(exp_f[0]));
            check("cycle_a", 32'(cyc_a), exp_cyc[0] & 32'h0000_00FF);
            check("retired_a", 32'(ret_a), exp_ret[0] & 32'h0000_00FF);
            check("flags_b", 32'(act_b), 32'(exp_f[1]));
            check("cycle_b", cyc_b, exp_cyc[1]);
            check("retired_b", ret_b, exp_ret[1]);
        end
    end

    // Advance one clock; fold the finished cycle into the counter model.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                exp_cyc[d] = 0;
                exp_ret[d] = 0;
            end else begin
                if (exp_f[d].busy) exp_cyc[d]++;
                if (exp_f[d].pc_en) exp_ret[d]++;
            end
        end
    endtask

    // Random values on every input; callers override the ones that matter.
    task automatic junk(input int d);
        rst[d]        = 1'b0;
        run[d]        = 1'($urandom);
        halt_req[d]   = 1'($urandom);
        inst_ready[d] = 1'($urandom);
        mem_access[d] = 1'($urandom);
        reg_write[d]  = 1'($urandom);
        mem_ready[d]  = 1'($urandom);
    endtask

    function automatic instr_t mk(input int fdly, input bit macc, input int mdly, input bit rw,
                                  input bit wb_run, input bit wb_halt, input bit abort_mem);
        instr_t in;
        in.fdly = fdly; in.macc = macc; in.mdly = mdly; in.rw = rw;
        in.wb_run = wb_run; in.wb_halt = wb_halt; in.abort_mem = abort_mem;
        return in;
    endfunction

    function automatic instr_t rand_instr(input int maxf, input int maxm, input int p_halt);
        instr_t in;
        in.fdly      = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, maxf));
        in.macc      = 1'($urandom);
        in.mdly      = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, maxm));
        in.rw        = 1'($urandom);
        in.wb_run    = $urandom_range(0, 9) < 7;
        in.wb_halt   = $urandom_range(0, 99) < p_halt;
        in.abort_mem = 1'b0;
        return in;
    endfunction

    task automatic reset_dut(input int d);
        tick();
        junk(d);
        rst[d]           = 1'b1;
        exp_f[d]         = '0;
        pending_fetch[d] = 1'b0;
    endtask

    task automatic idle(input int d);
        tick();
        junk(d);
        run[d]   = 1'b0;
        exp_f[d] = '0;
    endtask

    task automatic hold(input int d, input flags_t f, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            junk(d);
            exp_f[d] = f;
        end
    endtask

    // Expand one instruction plan into cycles. res: 0 retired, 1 timeout, 2 reset-aborted.
    task automatic do_instr(input int d, input bit skip, input int to, input instr_t in, output int res);
        flags_t f;
        int     nw;
        bit     tmo;
        res = 0;
        tmo = (to != 0) && (in.fdly >= to);
        nw  = tmo ? to : in.fdly;
        for (int w = 0; w < nw; w++) begin
            tick(); junk(d); inst_ready[d] = 1'b0;
            f = '0; f.inst_req = 1'b1; f.busy = 1'b1; exp_f[d] = f;
        end
        if (tmo) begin
            tick(); junk(d);
            f = '0; f.timeout_err = 1'b1; exp_f[d] = f;
            res = 1;
            return;
        end
        tick(); junk(d); inst_ready[d] = 1'b1;
        f = '0; f.inst_req = 1'b1; f.if_en = 1'b1; f.busy = 1'b1; exp_f[d] = f;
        tick(); junk(d); mem_access[d] = in.macc;
        f = '0; f.id_en = 1'b1; f.busy = 1'b1; exp_f[d] = f;
        tick(); junk(d); mem_access[d] = in.macc;
        f = '0; f.ex_en = 1'b1; f.busy = 1'b1; exp_f[d] = f;
        if (in.macc) begin
            tmo = (to != 0) && (in.mdly >= to);
            nw  = tmo ? to : in.mdly;
            for (int w = 0; w < nw; w++) begin
                tick(); junk(d); mem_access[d] = 1'b1; mem_ready[d] = 1'b0;
                f = '0; f.mem_req = 1'b1; f.busy = 1'b1; exp_f[d] = f;
            end
            if (tmo) begin
                tick(); junk(d);
                f = '0; f.timeout_err = 1'b1; exp_f[d] = f;
                res = 1;
                return;
            end
            tick(); junk(d); mem_access[d] = 1'b1;
            if (in.abort_mem) begin
                rst[d]   = 1'b1;
                exp_f[d] = '0;
                res      = 2;
                return;
            end
            mem_ready[d] = 1'b1;
            f = '0; f.mem_req = 1'b1; f.mem_en = 1'b1; f.busy = 1'b1; exp_f[d] = f;
        end else if (!skip) begin
            tick(); junk(d); mem_access[d] = 1'b0;
            f = '0; f.busy = 1'b1; exp_f[d] = f;
        end
        tick(); junk(d);
        mem_access[d] = in.macc; reg_write[d] = in.rw;
        run[d] = in.wb_run; halt_req[d] = in.wb_halt;
        f = '0; f.pc_en = 1'b1; f.wb_en = in.rw; f.busy = 1'b1; exp_f[d] = f;
    endtask

    task automatic go(input int d, input instr_t in, output int res);
        bit skip;
        int to;
        skip = (d == 0);
        to   = (d == 0) ? int'(TO_A) : 0;
        if (!pending_fetch[d]) begin
            tick(); junk(d); run[d] = 1'b1; exp_f[d] = '0;
        end
        do_instr(d, skip, to, in, res);
        pending_fetch[d] = (res == 0) && in.wb_run && !in.wb_halt;
    endtask

    // Random session; errors and halts are followed by a reset.
    task automatic random_session(input int d, input int n, input int maxf, input int maxm);
        instr_t in;
        int     res;
        flags_t f;
        for (int i = 0; i < n; i++) begin
            in = rand_instr(maxf, maxm, 4);
            go(d, in, res);
            if (res == 1) begin
                f = '0; f.timeout_err = 1'b1;
                hold(d, f, 2);
                reset_dut(d);
            end else if (in.wb_halt) begin
                f = '0; f.halted = 1'b1;
                hold(d, f, 3);
                reset_dut(d);
            end else if (!in.wb_run) begin
                for (int k = 0; k < int'($urandom_range(0, 2)); k++) idle(d);
            end
        end
    endtask

    initial begin
        instr_t in;
        int     res;
        flags_t f;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; run[d] = 1'b0; halt_req[d] = 1'b0; inst_ready[d] = 1'b0;
            mem_access[d] = 1'b0; reg_write[d] = 1'b0; mem_ready[d] = 1'b0;
            exp_f[d] = '0; exp_cyc[d] = 0; exp_ret[d] = 0; pending_fetch[d] = 1'b0;
        end
        tick();
        chk_en = 1'b1;
        check("reset_busy_a", 32'(a_busy), 32'd0);

        // Zero-wait ALU instruction: four busy cycles, one retire.
        in = mk(0, 0, 0, 1, 0, 0, 0);
        go(0, in, res);
        idle(0);
        #2;
        check("alu_retired", 32'(ret_a), 32'd1);
        check("alu_cycles", 32'(cyc_a), 32'd4);

        // Load with mem_ready three cycles late: eight cycles.
        reset_dut(0);
        in = mk(0, 1, 3, 1, 0, 0, 0);
        go(0, in, res);
        idle(0);
        #2;
        check("load_cycles", 32'(cyc_a), 32'd8);

        // Fetch never ready: error after four request cycles.
        reset_dut(0);
        in = mk(4, 0, 0, 1, 1, 0, 0);
        go(0, in, res);
        #2;
        check("tmo_flag", 32'(a_timeout_err), 32'd1);
        check("tmo_req_drop", 32'(a_inst_req), 32'd0);
        f = '0; f.timeout_err = 1'b1;
        hold(0, f, 3);

        // Ready in the expiry cycle wins: 3 waits + F,D,E,W.
        reset_dut(0);
        in = mk(3, 0, 0, 0, 0, 0, 0);
        go(0, in, res);
        idle(0);
        #2;
        check("expiry_ready_cycles", 32'(cyc_a), 32'd7);
        check("expiry_ready_no_err", 32'(a_timeout_err), 32'd0);

        // Data-side timeout.
        reset_dut(0);
        in = mk(0, 1, 4, 1, 1, 0, 0);
        go(0, in, res);
        hold(0, f, 2);

        // Halt taken at WB.
        reset_dut(0);
        in = mk(1, 1, 1, 1, 1, 1, 0);
        go(0, in, res);
        f = '0; f.halted = 1'b1;
        hold(0, f, 4);
        #2;
        check("halt_halted", 32'(a_halted), 32'd1);
        check("halt_busy", 32'(a_busy), 32'd0);

        // Reset while MEM is requesting.
        reset_dut(0);
        in = mk(0, 1, 2, 1, 1, 0, 1);
        go(0, in, res);
        pending_fetch[0] = 1'b0;
        idle(0);
        #2;
        check("abort_cycles", 32'(cyc_a), 32'd0);
        check("abort_mem_req", 32'(a_mem_req), 32'd0);

        // 260 back-to-back retires wrap the 8-bit counter.
        reset_dut(0);
        for (int i = 0; i < 260; i++) begin
            in = rand_instr(3, 3, 0);
            in.wb_run = (i != 259);
            go(0, in, res);
        end
        idle(0);
        #2;
        check("wrap_retired", 32'(ret_a), 32'd4);

        random_session(0, 150, 5, 5);
        reset_dut(0);

        // Instance B: forced MEM visit, no timeout.
        reset_dut(1);
        in = mk(0, 0, 0, 1, 0, 0, 0);
        go(1, in, res);
        idle(1);
        #2;
        check("nomem_visit_cycles", cyc_b, 32'd5);
        in = mk(20, 1, 25, 1, 0, 0, 0);
        go(1, in, res);
        idle(1);
        #2;
        check("long_wait_no_err", 32'(b_timeout_err), 32'd0);
        random_session(1, 100, 20, 20);
        reset_dut(1);
        tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
